seq_alu_core: RTL
=================

# seq_alu_core

Parametrised multi-cycle ALU core; the successor to the single-cycle combinational ALU behind the `tt_um_*` top-level pin mapping. It adds width parametrisation, iterative multiply/divide, a start/busy/done handshake, registered status flags and an error output. The `tt_um_*` top wraps it and maps operands and results onto `ui_in`, `uio_in`, `uo_out` and `uio_out`.

## Interface
Parameters:
- `WIDTH`, default 8: operand width; legal range 4..32.
- `SHW`, default `$clog2(WIDTH)`: shift-amount width (derived, not overridden).

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `ena` in 1: design enable; when low, all state holds (clock-enable semantics).
- `start` in 1: request a new operation; sampled only in IDLE with `ena`=1.
- `op` in 4: opcode, 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SHL, 6 SHR, 7 MUL, 8 DIV; 9–15 illegal.
- `a`, `b` in WIDTH: operands, latched on the accepting edge.
- `busy` out 1: high while in CALC.
- `done` out 1: one-cycle pulse when a result is committed.
- `result_lo` out WIDTH: low result; quotient for DIV.
- `result_hi` out WIDTH: MUL high half; remainder for DIV; 0 for other ops.
- `flags` out 4: {Z, N, C, V}.
- `err` out 1: set with `done` on DIV-by-zero or an illegal op; cleared on the next accepted start.

## Operation
- FSM states: IDLE and CALC.
  - IDLE + `start` + `ena`, single-cycle op: commit on that edge and stay in IDLE.
  - IDLE + `start` + `ena`, MUL or DIV: latch operands, counter set to WIDTH, go to CALC.
  - CALC: one iteration per enabled edge; when the counter reaches 0, commit and return to IDLE.
- `start` while `busy` is ignored; no queueing.
- A new start is accepted in the same cycle `done` is high (back-to-back).
- ADD/SUB: WIDTH-bit wrap. C = carry out for ADD, borrow for SUB. V = two's-complement overflow.
- Logic ops: C=0, V=0.
- SHL/SHR: logical shift of `a` by `b[SHW-1:0]`. C = last bit shifted out (0 when the amount is 0). V=0.
- MUL: unsigned shift-add, full 2·WIDTH product. C = (`result_hi` != 0). V=0.
- DIV: unsigned restoring division. C=0, V=0.
  - Divide by zero: quotient all ones, remainder = `a`, `err`=1, one-cycle latency (CALC is skipped).
- Illegal op: results 0, flags 0000, `err`=1, one-cycle latency.
- Z = 1 when the full visible result is zero (lo for single-width ops, {hi,lo} for MUL/DIV).
- N = MSB of the most-significant valid half.
- `result_*`, `flags` and `err` change only on commit and hold until the next commit.

## Timing
- Reset (async assert, sync release): state IDLE, counter 0, all outputs 0 (`busy` 0, `done` 0, results 0, flags 0000, `err` 0).
- Single-cycle ops: start accepted at edge T0; `done` and results visible after T0, i.e. latency 1.
- MUL/DIV: `busy` rises after T0; iterations run at T1..TW; commit at TW. `done` is high and `busy` low after TW, i.e. latency WIDTH.
- `ena` low in CALC: counter and datapath freeze, `busy` stays high, latency stretches by the number of disabled cycles.
- `ena` low in the `done` cycle: `done` holds high until the next enabled edge, then clears.
- Reset asserted mid-CALC: operation aborted immediately; no `done` is produced.
- `a`, `b` and `op` may change freely after the accepting edge.

## Structure
- Package `seq_alu_pkg`: opcode enum (`OP_ADD`..`OP_DIV`), FSM state enum, flag bit indices (`FLAG_Z`=3, `FLAG_N`=2, `FLAG_C`=1, `FLAG_V`=0).
- Sub-module `seq_alu_muldiv`: iterative shift-add multiplier and restoring divider sharing one WIDTH-bit adder. It exposes load/step/last controls and the hi/lo registers. The top holds the FSM, the single-cycle datapath, flag generation and output registers.

## Test plan
All scenarios use WIDTH=8.
- ADD a=200, b=100 -> one cycle after start: `result_lo`=0x2C, flags Z0 N0 C1 V0, `done` one pulse. ADD 0x7F+0x01 -> 0x80, N1 V1.
- SUB a=5, b=7 -> 0xFE, N1 C1. SHL a=0x81, b=1 -> 0x02, C1. SHR b=0 -> C0.
- MUL a=255, b=255 -> `busy` for 8 cycles, `done` 8 cycles after the accepting edge, hi=0xFE, lo=0x01, C1. A `start` pulsed mid-operation is ignored.
- DIV a=100, b=7 -> quotient 14, remainder 2, latency 8. DIV a=9, b=0 -> lo=0xFF, hi=9, `err`=1, latency 1. op=12 -> `err`=1, results 0.
- MUL with `ena` held low for 3 cycles mid-CALC -> `done` at latency 11, correct product. Back-to-back ADD started in the `done` cycle -> accepted.
- `rst_n` pulsed low at iteration 4 of a DIV -> outputs immediately 0, `busy` 0, no `done`. The next MUL completes correctly.

Source files
------------

// File: rtl/seq_alu_pkg.sv
// Shared opcodes, FSM states and flag bit positions for the sequential ALU core.
package seq_alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_AND = 4'd2,
    OP_OR  = 4'd3,
    OP_XOR = 4'd4,
    OP_SHL = 4'd5,
    OP_SHR = 4'd6,
    OP_MUL = 4'd7,
    OP_DIV = 4'd8
  } op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_CALC = 1'b1
  } state_e;

  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/seq_alu_muldiv.sv
// Iterative unsigned shift-add multiplier / restoring divider sharing one WIDTH-bit adder.
// hi_nxt/lo_nxt expose the post-iteration values so the caller can commit on the final step.
module seq_alu_muldiv
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             load,
  input  logic             step,
  input  logic             div_mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             last,
  output logic [WIDTH-1:0] hi_nxt,
  output logic [WIDTH-1:0] lo_nxt
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic [WIDTH-1:0] m_q;
  logic [WIDTH-1:0] div_rem;
  logic [WIDTH-1:0] add_x;
  logic [WIDTH-1:0] add_y;
  logic             add_cin;
  logic [WIDTH:0]   add_sum;
  logic             div_ok;

  // Divide: partial remainder shifted left with the next dividend bit; subtract via ~m + 1.
  assign div_rem = {hi_q[WIDTH-2:0], lo_q[WIDTH-1]};

  always_comb begin
    add_y   = div_mode ? div_rem : hi_q;
    add_x   = div_mode ? ~m_q : m_q;
    add_cin = div_mode;
  end

  assign add_sum = {1'b0, add_y} + {1'b0, add_x} + {{WIDTH{1'b0}}, add_cin};
  // The bit shifted out of hi makes the trial remainder exceed any divisor.
  assign div_ok  = hi_q[WIDTH-1] | add_sum[WIDTH];

  always_comb begin
    if (div_mode) begin
      hi_nxt = div_ok ? add_sum[WIDTH-1:0] : div_rem;
      lo_nxt = {lo_q[WIDTH-2:0], div_ok};
    end else if (lo_q[0]) begin
      hi_nxt = add_sum[WIDTH:1];
      lo_nxt = {add_sum[0], lo_q[WIDTH-1:1]};
    end else begin
      hi_nxt = {1'b0, hi_q[WIDTH-1:1]};
      lo_nxt = {hi_q[0], lo_q[WIDTH-1:1]};
    end
  end

  assign last = (cnt_q == CW'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (ena) begin
      if (load) begin
        cnt_q <= CW'(WIDTH);
      end else if (step && (cnt_q != '0)) begin
        cnt_q <= cnt_q - CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (ena) begin
      if (load) begin
        hi_q <= '0;
        lo_q <= a;
        m_q  <= b;
      end else if (step) begin
        hi_q <= hi_nxt;
        lo_q <= lo_nxt;
      end
    end
  end

endmodule

// File: rtl/seq_alu_core.sv
// Multi-cycle ALU core: IDLE/CALC FSM, single-cycle datapath, flag generation and
// registered results; MUL and non-zero DIV iterate in seq_alu_muldiv.
module seq_alu_core
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic [3:0]       flags,
  output logic             err
);

  localparam int MSB = WIDTH - 1;

  function automatic logic [3:0] mk_flags(input logic z, input logic n,
                                          input logic c, input logic v);
    logic [3:0] f;
    f         = '0;
    f[FLAG_Z] = z;
    f[FLAG_N] = n;
    f[FLAG_C] = c;
    f[FLAG_V] = v;
    return f;
  endfunction

  state_e           state_q;
  state_e           state_d;
  logic             div_q;
  logic             load;
  logic             step;
  logic             commit;
  logic             md_last;
  logic [WIDTH-1:0] md_hi;
  logic [WIDTH-1:0] md_lo;
  logic [WIDTH-1:0] nxt_lo;
  logic [WIDTH-1:0] nxt_hi;
  logic [3:0]       nxt_flags;
  logic             nxt_err;

  logic [SHW-1:0]   amt;
  logic [WIDTH:0]   add_w;
  logic [WIDTH:0]   sub_w;
  logic [WIDTH:0]   shl_w;
  logic [WIDTH:0]   shr_w;
  logic [WIDTH-1:0] sc_lo;
  logic             sc_c;
  logic             sc_v;
  logic             sc_err;

  assign amt   = b[SHW-1:0];
  assign add_w = {1'b0, a} + {1'b0, b};
  assign sub_w = {1'b0, a} - {1'b0, b};
  // One guard bit on each side catches the last bit shifted out.
  assign shl_w = {1'b0, a} << amt;
  assign shr_w = {a, 1'b0} >> amt;

  always_comb begin
    sc_lo  = '0;
    sc_c   = 1'b0;
    sc_v   = 1'b0;
    sc_err = 1'b0;
    case (op)
      OP_ADD: begin
        sc_lo = add_w[MSB:0];
        sc_c  = add_w[WIDTH];
        sc_v  = (a[MSB] == b[MSB]) && (add_w[MSB] != a[MSB]);
      end
      OP_SUB: begin
        sc_lo = sub_w[MSB:0];
        sc_c  = sub_w[WIDTH];
        sc_v  = (a[MSB] != b[MSB]) && (sub_w[MSB] != a[MSB]);
      end
      OP_AND: sc_lo = a & b;
      OP_OR:  sc_lo = a | b;
      OP_XOR: sc_lo = a ^ b;
      OP_SHL: begin
        sc_lo = shl_w[MSB:0];
        sc_c  = shl_w[WIDTH];
      end
      OP_SHR: begin
        sc_lo = shr_w[WIDTH:1];
        sc_c  = shr_w[0];
      end
      OP_MUL, OP_DIV: sc_err = 1'b0;
      default: sc_err = 1'b1;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    load      = 1'b0;
    step      = 1'b0;
    commit    = 1'b0;
    nxt_lo    = result_lo;
    nxt_hi    = result_hi;
    nxt_flags = flags;
    nxt_err   = err;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if ((op == OP_MUL) || ((op == OP_DIV) && (b != '0))) begin
            load    = 1'b1;
            state_d = ST_CALC;
          end else if (op == OP_DIV) begin
            // Divide by zero resolves immediately without iterating.
            commit    = 1'b1;
            nxt_lo    = '1;
            nxt_hi    = a;
            nxt_flags = mk_flags(1'b0, a[MSB], 1'b0, 1'b0);
            nxt_err   = 1'b1;
          end else begin
            commit    = 1'b1;
            nxt_lo    = sc_lo;
            nxt_hi    = '0;
            nxt_flags = sc_err ? 4'b0000 : mk_flags(sc_lo == '0, sc_lo[MSB], sc_c, sc_v);
            nxt_err   = sc_err;
          end
        end
      end
      ST_CALC: begin
        step = 1'b1;
        if (md_last) begin
          commit    = 1'b1;
          state_d   = ST_IDLE;
          nxt_lo    = md_lo;
          nxt_hi    = md_hi;
          nxt_flags = mk_flags({md_hi, md_lo} == '0, md_hi[MSB],
                               !div_q && (md_hi != '0), 1'b0);
          nxt_err   = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      div_q     <= 1'b0;
      done      <= 1'b0;
      result_lo <= '0;
      result_hi <= '0;
      flags     <= '0;
      err       <= 1'b0;
    end else if (ena) begin
      state_q <= state_d;
      done    <= commit;
      if (load) begin
        div_q <= (op == OP_DIV);
        err   <= 1'b0;
      end
      if (commit) begin
        result_lo <= nxt_lo;
        result_hi <= nxt_hi;
        flags     <= nxt_flags;
        err       <= nxt_err;
      end
    end
  end

  assign busy = (state_q == ST_CALC);

  seq_alu_muldiv #(
    .WIDTH(WIDTH)
  ) u_muldiv (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .load    (load),
    .step    (step),
    .div_mode(div_q),
    .a       (a),
    .b       (b),
    .last    (md_last),
    .hi_nxt  (md_hi),
    .lo_nxt  (md_lo)
  );

endmodule
